// File: rtl/alu_seq_param.sv
// Registered, parametrised ALU with valid/ready handshake and an iterative shift-add multiplier.
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_seq_param #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Is_Greater,
`ifdef ALU_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic             busy
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             gt_q, gt_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             mgt_q, mgt_d;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
`ifdef ALU_OVERFLOW_EN
    logic             ov_q, ov_d;
`endif

    // Single-cycle ops; MUL is handled by the iterative path and yields 0 here.
    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [SHW-1:0]          sh;
        logic [WIDTH-1:0]        r;
        xs = x;
        ys = y;
        sh = y[SHW-1:0];
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_NOR:  r = ~(x | y);
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = xs >>> sh;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (xs < ys)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef ALU_OVERFLOW_EN
    function automatic logic ovf_f(input logic [3:0] op,
                                   input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] d;
        logic             o;
        s = x + y;
        d = x - y;
        case (op)
            OP_ADD:  o = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
            OP_SUB:  o = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
            default: o = 1'b0;
        endcase
        return o;
    endfunction
`endif

    assign alu_res   = alu_f(ALUOp, a, b);
    assign in_ready  = (state_q == S_IDLE) && (!vld_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == S_MUL);
    assign out_valid = vld_q;
    assign Result    = res_q;
    assign Zero      = zero_q;
    assign Is_Greater = gt_q;
`ifdef ALU_OVERFLOW_EN
    assign Overflow  = ov_q;
`endif

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        zero_d   = zero_q;
        gt_d     = gt_q;
        vld_d    = vld_q && !out_ready;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mgt_d    = mgt_q;
`ifdef ALU_OVERFLOW_EN
        ov_d     = ov_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ALUOp == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mgt_d    = (a > b);
                        state_d  = S_MUL;
                    end else begin
                        res_d  = alu_res;
                        zero_d = (alu_res == '0);
                        gt_d   = (a > b);
                        vld_d  = 1'b1;
`ifdef ALU_OVERFLOW_EN
                        ov_d   = ovf_f(ALUOp, a, b);
`endif
                    end
                end
            end
            S_MUL: begin
                // Output slot was guaranteed free at accept, so completion never waits.
                if (cnt_q == CNTW'(WIDTH)) begin
                    res_d   = acc_q;
                    zero_d  = (acc_q == '0);
                    gt_d    = mgt_q;
                    vld_d   = 1'b1;
                    state_d = S_IDLE;
`ifdef ALU_OVERFLOW_EN
                    ov_d    = 1'b0;
`endif
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNTW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            zero_q   <= 1'b1;
            gt_q     <= 1'b0;
            vld_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mgt_q    <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ov_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            gt_q     <= gt_d;
            vld_q    <= vld_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mgt_q    <= mgt_d;
`ifdef ALU_OVERFLOW_EN
            ov_q     <= ov_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param with a cycle-level reference model and per-cycle compare.
module tb_alu_seq_param;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   ALUOp;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Is_Greater;
    logic         busy;
`ifdef ALU_OVERFLOW_EN
    logic         Overflow;
`endif

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .ALUOp(ALUOp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result(Result),
        .Zero(Zero),
        .Is_Greater(Is_Greater),
`ifdef ALU_OVERFLOW_EN
        .Overflow(Overflow),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be, from the operation definitions.
    logic         m_valid;
    logic [W-1:0] m_res;
    logic         m_zero, m_gt, m_ov;
    int           m_left;
    logic [W-1:0] m_pend;
    logic         m_pend_gt;

    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        int sh;
        sh = int'(y % W);
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b1100: return ~(x | y);
            4'b0011: return x ^ y;
            4'b0111: return x << sh;
            4'b0100: return x >> sh;
            4'b0101: return $signed(x) >>> sh;
            4'b1000: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'b1001: return (x < y) ? 64'd1 : 64'd0;
            4'b1010: return x * y;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_ov(input logic [3:0] op, input logic [W-1:0] x,
                                    input logic [W-1:0] y);
        longint sx, sy;
        logic [W:0] dummy;
        sx = $signed(x);
        sy = $signed(y);
        dummy = '0;
        if (op == 4'b0010) return ((sx >= 0) == (sy >= 0)) && (($signed(x + y) >= 0) != (sx >= 0));
        if (op == 4'b0110) return ((sx >= 0) != (sy >= 0)) && (($signed(x - y) >= 0) != (sx >= 0));
        return dummy[0];
    endfunction

    function automatic logic exp_ready();
        return (m_left == 0) && (!m_valid || out_ready);
    endfunction

    task automatic model_step();
        logic rdy;
        if (reset) begin
            m_valid = 1'b0; m_res = '0; m_zero = 1'b1; m_gt = 1'b0; m_ov = 1'b0;
            m_left = 0; m_pend = '0; m_pend_gt = 1'b0;
        end else begin
            rdy = exp_ready();
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = m_pend; m_zero = (m_pend == 0); m_gt = m_pend_gt; m_ov = 1'b0;
                    m_valid = 1'b1;
                end
            end else if (in_valid && rdy) begin
                if (ALUOp == 4'b1010) begin
                    m_left = W + 1; m_pend = a * b; m_pend_gt = (a > b);
                end else begin
                    m_res = ref_res(ALUOp, a, b); m_zero = (m_res == 0);
                    m_gt = (a > b); m_ov = ref_ov(ALUOp, a, b); m_valid = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk1("out_valid", out_valid, m_valid);
            chk1("in_ready", in_ready, exp_ready());
            chk1("busy", busy, m_left > 0);
            if (m_valid) begin
                chk("Result", Result, m_res);
                chk1("Zero", Zero, m_zero);
                chk1("Is_Greater", Is_Greater, m_gt);
`ifdef ALU_OVERFLOW_EN
                chk1("Overflow", Overflow, m_ov);
`endif
            end
        end
    end

    // Call only at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int waited);
        logic r;
        in_valid = 1'b1; ALUOp = op; a = x; b = y;
        waited = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r = exp_ready();
            @(posedge clk);
            #2;
            waited++;
            if (r) break;
        end
        if (waited >= 200) chk("accept_timeout", 64'(waited), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic op_check(input string name, input logic [3:0] op, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                            input logic eg);
        int w;
        issue(op, x, y, w);
        chk({name, "_accept_cycles"}, 64'(w), 64'd1);
        chk1({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_res"}, Result, er);
        chk1({name, "_zero"}, Zero, ez);
        chk1({name, "_gt"}, Is_Greater, eg);
    endtask

    initial begin
        int w;
        int lat;
        logic seen;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ALUOp = 4'b0000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_result", Result, 64'd0);
        chk1("rst_zero", Zero, 1'b1);
        chk1("rst_gt", Is_Greater, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #2;

        op_check("add", 4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0);
        op_check("sub_eq", 4'b0110, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0);
        op_check("sub_wrap", 4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        op_check("sra", 4'b0101, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1'b1);
        op_check("slt", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b1);
        op_check("sltu", 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1);
        op_check("and", 4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0);
        op_check("xor", 4'b0011, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b1);
        op_check("nor", 4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        op_check("sll", 4'b0111, 64'd1, 64'h104, 64'd16, 1'b0, 1'b0);
        op_check("srl", 4'b0100, 64'h100, 64'h44, 64'h10, 1'b0, 1'b1);
        op_check("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
`ifdef ALU_OVERFLOW_EN
        chk1("ovf_add", Overflow, 1'b1);
`endif
        op_check("undef", 4'b1111, 64'd3, 64'd2, 64'd0, 1'b1, 1'b1);
`ifdef ALU_OVERFLOW_EN
        chk1("ovf_undef", Overflow, 1'b0);
`endif

        // Multiply: fixed latency of WIDTH+1 edges from accept.
        issue(4'b1010, 64'd123456, 64'd789, w);
        chk1("mul_busy0", busy, 1'b1);
        chk1("mul_ready0", in_ready, 1'b0);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #2;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("mul_latency", 64'(lat), 64'(W + 1));
        chk("mul_res", Result, 64'd97406784);
        chk1("mul_zero", Zero, 1'b0);
        chk1("mul_gt", Is_Greater, 1'b1);

        // Reset partway through a multiply must discard it.
        issue(4'b1010, 64'h1234, 64'h5678, w);
        repeat (29) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        chk1("abort_valid", out_valid, 1'b0);
        chk("abort_result", Result, 64'd0);
        chk1("abort_zero", Zero, 1'b1);
        chk1("abort_gt", Is_Greater, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #2;
            if (out_valid) seen = 1'b1;
        end
        chk1("abort_no_result", seen, 1'b0);

        // Backpressure: result held while consumer stalls.
        out_ready = 1'b0;
        issue(4'b0010, 64'd1, 64'd1, w);
        chk("bp_res0", Result, 64'd2);
        repeat (4) begin
            @(posedge clk);
            #2;
            chk1("bp_valid", out_valid, 1'b1);
            chk("bp_res", Result, 64'd2);
            chk1("bp_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        issue(4'b0001, 64'hF0, 64'h0F, w);
        chk("bp_same_cycle", 64'(w), 64'd1);
        chk1("bp_or_valid", out_valid, 1'b1);
        chk("bp_or_res", Result, 64'hFF);

        // Back-to-back throughput.
        op_check("b2b_0", 4'b0010, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
        op_check("b2b_1", 4'b0010, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk1("idle_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
